// File: rtl/drum_step_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drum_step_player: four-bank step-pattern player with a drift-free BPM      |
// | accumulator; optional per-voice mute when DRUM_MUTE_EN is defined.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module drum_step_player #(
  parameter int CLK_HZ  = 50000000,
  parameter int STEPS   = 16,
  parameter int VOICES  = 6,
  parameter int BPM_MIN = 30
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [7:0]                 bpm,
  input  logic                       run,
  input  logic [1:0]                 play_sel,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_sel,
  input  logic [STEPS*VOICES-1:0]    wr_data,
`ifdef DRUM_MUTE_EN
  input  logic [VOICES-1:0]          mute,
`endif
  output logic [VOICES-1:0]          trig,
  output logic [$clog2(STEPS)-1:0]   step,
  output logic                       bar_start,
  output logic                       playing,
  output logic [1:0]                 cur_bank
);

  localparam int LIMIT = CLK_HZ * 15;
  localparam int ACC_W = $clog2(CLK_HZ * 15 + 256);
  localparam int SW    = $clog2(STEPS);
  localparam int PW    = STEPS * VOICES;
  localparam logic [ACC_W-1:0] LIMIT_V   = ACC_W'(LIMIT);
  localparam logic [SW-1:0]    LAST_STEP = SW'(STEPS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_RUN = 2'd2} state_t;

  state_t            state;
  logic [PW-1:0]     banks [4];
  logic [ACC_W-1:0]  acc;
  logic [SW-1:0]     step_cnt;
  logic              tick;

  logic [7:0]        bpm_eff;
  logic [ACC_W-1:0]  acc_sum;
  logic [SW-1:0]     next_step;
  logic [SW-1:0]     fire_step;
  logic [1:0]        fire_bank;
  logic [PW-1:0]     fire_word;
  logic [VOICES-1:0] fire_bits;
  logic [VOICES-1:0] fire_trig;

  assign bpm_eff   = (bpm < 8'(BPM_MIN)) ? 8'(BPM_MIN) : bpm;
  assign acc_sum   = acc + ACC_W'(bpm_eff);
  assign next_step = (step_cnt == LAST_STEP) ? '0 : step_cnt + 1'b1;

  // Bank switches only at the bar boundary, so a wrapping fire reads play_sel directly.
  assign fire_step = (state == S_START) ? '0 : next_step;
  assign fire_bank = (state == S_START || next_step == '0) ? play_sel : cur_bank;
  assign fire_word = banks[fire_bank];

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    logic [STEPS-1:0] row;
    assign row          = fire_word[v*STEPS +: STEPS];
    assign fire_bits[v] = row[fire_step];
  end

`ifdef DRUM_MUTE_EN
  assign fire_trig = fire_bits & ~mute;
`else
  assign fire_trig = fire_bits;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int b = 0; b < 4; b++) banks[b] <= '0;
    end else if (wr_en) begin
      banks[wr_sel] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      acc       <= '0;
      step_cnt  <= '0;
      tick      <= 1'b0;
      trig      <= '0;
      step      <= '0;
      bar_start <= 1'b0;
      playing   <= 1'b0;
      cur_bank  <= '0;
    end else begin
      trig      <= '0;
      bar_start <= 1'b0;
      case (state)
        S_IDLE: begin
          playing  <= 1'b0;
          acc      <= '0;
          step_cnt <= '0;
          tick     <= 1'b0;
          if (run) state <= S_START;
        end
        S_START: begin
          acc       <= '0;
          step_cnt  <= '0;
          tick      <= 1'b0;
          cur_bank  <= play_sel;
          trig      <= fire_trig;
          step      <= '0;
          bar_start <= 1'b1;
          playing   <= 1'b1;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (!run) begin
            // A tick pending in this cycle is dropped: nothing fires on the way out.
            state    <= S_IDLE;
            playing  <= 1'b0;
            acc      <= '0;
            step_cnt <= '0;
            tick     <= 1'b0;
          end else begin
            if (tick) begin
              step_cnt <= next_step;
              step     <= next_step;
              trig     <= fire_trig;
              if (next_step == '0) begin
                cur_bank  <= play_sel;
                bar_start <= 1'b1;
              end
            end
            if (acc_sum >= LIMIT_V) begin
              acc  <= acc_sum - LIMIT_V;
              tick <= 1'b1;
            end else begin
              acc  <= acc_sum;
              tick <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/drum_step_player.md
# drum_step_player

Pattern playback engine for the drum machine: stores four 16-step x 6-voice pattern banks written by the front-panel editor and plays the selected bank at the current BPM, emitting one-cycle trigger pulses per voice. It sits between the BPM/pattern editing logic (the writer of BPM value and pattern maps) and the voice generators (consumers of trigger pulses).

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- STEPS, 16, steps per pattern (one step = one 16th note)
- VOICES, 6, drum voices per step (STEPS*VOICES = 96-bit pattern word)
- BPM_MIN, 30, lower clamp applied to bpm input
- clk  in  1  system clock, all logic on rising edge
- nrst  in  1  reset, asynchronous, active-low
- bpm  in  8  tempo in beats per minute
- run  in  1  level: 1 = play, 0 = stop
- play_sel  in  2  bank requested for playback
- wr_en  in  1  single-cycle pattern write strobe
- wr_sel  in  2  bank written when wr_en=1
- wr_data  in  STEPS*VOICES  pattern word; bit v*STEPS+s = voice v, step s
- mute  in  VOICES  per-voice mute (present only with DRUM_MUTE_EN)
- trig  out  VOICES  one-cycle trigger pulses for the current step
- step  out  clog2(STEPS)  index of the last fired step
- bar_start  out  1  one-cycle pulse coincident with trig of step 0
- playing  out  1  1 while in RUN
- cur_bank  out  2  bank currently playing

## Operation
- Storage: 4 x (STEPS*VOICES) registers; wr_en loads wr_data into bank wr_sel whole-word. Allowed in any state.
- Tempo: accumulator acc, width clog2(CLK_HZ*15+256). Each RUN cycle acc += bpm_eff; when acc+bpm_eff >= LIMIT = CLK_HZ*15, acc <= acc+bpm_eff-LIMIT and a step tick is generated. bpm_eff = max(bpm, BPM_MIN). Step rate = 4*bpm_eff/60 per second, exact on average (no drift).
- FSM IDLE -> START when run=1; START (one cycle): step counter=0, acc=0, cur_bank<=play_sel, fire step 0 -> RUN. RUN -> IDLE when run=0.
- On tick in RUN: step counter increments modulo STEPS, fires that step. On wrap to 0, cur_bank <= play_sel (bank change is quantized to bar boundary); bar_start pulses.
- Fire: trig[v] <= bank[cur_bank][v*STEPS+s], step <= s.
- Leaving RUN: trig=0, playing=0, acc=0, step counter=0; step output holds last value.

## Timing
- Reset: trig=0, step=0, bar_start=0, playing=0, cur_bank=0, acc=0, all banks=0, FSM=IDLE.
- run rising at edge N: START at N+1, trig/bar_start for step 0 registered at N+2; playing=1 from N+2.
- Tick decision at edge N -> trig/step/bar_start valid after edge N+1, high exactly one cycle.
- Write and fire of same bank in same cycle: fire uses pre-write contents; write visible from next cycle.
- bpm change: takes effect next cycle; acc not reset, current step not restarted.
- play_sel change mid-bar: ignored until wrap; change in same cycle as wrap is taken.
- run dropping in the same cycle as a tick: no trig issued.
- nrst asserted mid-play: all outputs to reset values immediately (asynchronous).

## Configuration
- DRUM_MUTE_EN defined: mute port exists; trig[v] <= pattern bit & ~mute[v], mute sampled at the fire cycle; step/bar_start unaffected.
- Not defined: no mute port; trig is the raw pattern bit.

## Test plan
- CLK_HZ=100 (LIMIT=1500), bpm=150, bank0 voice0 = 16'h1111 -> trig[0] pulses at steps 0,4,8,12, ticks every 10 cycles, bar_start every 160 cycles.
- bpm=0 with CLK_HZ=100, BPM_MIN=30 -> tick period 50 cycles; bpm 150->75 mid-bar -> period 10->20 cycles, no step skipped or repeated.
- play_sel 0->2 at step 5 -> steps 6..15 from bank0, step 0 of next bar from bank2, cur_bank=2 from that fire.
- wr_en to bank0 in same cycle as step 3 fire -> step 3 uses old bits, step 3 of next bar uses new bits.
- run low at step 7 then high -> trig=0 in IDLE, restart fires step 0 two cycles after run rises; nrst pulse mid-play -> all outputs and banks zero.
- DRUM_MUTE_EN, all-ones pattern, mute=6'b000011 -> trig=6'b111100 every step.
